// File: rtl/turn_input_ctrl_pkg.sv
// Shared definitions for the turn-signal front end and the downstream blink sequencer.
package turn_input_ctrl_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF    = 2'd0;
    localparam mode_t MODE_LEFT   = 2'd1;
    localparam mode_t MODE_RIGHT  = 2'd2;
    localparam mode_t MODE_HAZARD = 2'd3;

    typedef enum logic [1:0] {
        TURN_OFF   = 2'd0,
        TURN_LEFT  = 2'd1,
        TURN_RIGHT = 2'd2
    } turn_state_t;

    // Map the remembered turn selection onto the visible mode encoding.
    function automatic mode_t turn_to_mode(input turn_state_t s);
        case (s)
            TURN_LEFT:  return MODE_LEFT;
            TURN_RIGHT: return MODE_RIGHT;
            default:    return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/turn_input_ctrl_debounce.sv
// Two-flop synchroniser followed by a stability counter. The output only
// follows the input after it has disagreed for DEBOUNCE_CYCLES straight cycles.
module turn_input_ctrl_debounce #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pin into the clock domain; preset to the idle level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            dout <= RST_VAL;
        end else if (sync2 == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            dout <= sync2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/turn_input_ctrl.sv
// Turn-signal input front end: conditions the pushbutton and hazard switch,
// tracks the requested mode, and produces the blink step enable plus a
// sequence-clear pulse whenever the visible mode changes.
//
// turn_state | meaning
// TURN_OFF   | no turn requested
// TURN_LEFT  | left blinker requested
// TURN_RIGHT | right blinker requested
// (hazard is an override on top of turn_state, not a state of its own)
module turn_input_ctrl
    import turn_input_ctrl_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int STEP_HZ         = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       turn_btn,
    input  logic       hazard_sw,
    output logic [1:0] mode,
    output logic       step,
    output logic       seq_clear
);

    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic          btn_db;
    logic          sw_db;
    logic          btn_db_q;
    logic          sw_db_q;
    logic          press_ok;
    logic          mode_chg;
    mode_t         mode_nxt;
    turn_state_t   turn_state;
    turn_state_t   turn_state_nxt;
    logic [DW-1:0] div_cnt;

    // Button idles high (active-low), so it is preset released.
    turn_input_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (1'b1)
    ) u_btn_db (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (turn_btn),
        .dout   (btn_db)
    );

    turn_input_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (1'b0)
    ) u_sw_db (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (hazard_sw),
        .dout   (sw_db)
    );

    // Previous debounced values for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_db_q <= 1'b1;
            sw_db_q  <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            sw_db_q  <= sw_db;
        end
    end

    // Next turn selection, visible mode, and change detect. A press is dropped
    // if hazard is on or toggles in the same cycle, so hazard always wins.
    always_comb begin
        press_ok       = btn_db_q & ~btn_db & ~sw_db & ~sw_db_q;
        turn_state_nxt = turn_state;
        if (press_ok) begin
            case (turn_state)
                TURN_OFF:   turn_state_nxt = TURN_LEFT;
                TURN_LEFT:  turn_state_nxt = TURN_RIGHT;
                TURN_RIGHT: turn_state_nxt = TURN_OFF;
                default:    turn_state_nxt = TURN_OFF;
            endcase
        end
        mode_nxt = sw_db ? MODE_HAZARD : turn_to_mode(turn_state_nxt);
        mode_chg = (mode_nxt != mode);
    end

    // Turn state, registered mode, and the one-cycle clear on any mode change.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            turn_state <= TURN_OFF;
            mode       <= MODE_OFF;
            seq_clear  <= 1'b0;
        end else begin
            turn_state <= turn_state_nxt;
            mode       <= mode_nxt;
            seq_clear  <= mode_chg;
        end
    end

    // Blink-rate divider; a mode change restarts it and swallows a coincident step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            step    <= 1'b0;
        end else begin
            step <= (div_cnt == DIV_LAST) && !mode_chg;
            if (mode_chg || (div_cnt == DIV_LAST)) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_turn_input_ctrl.sv
// Self-checking bench for turn_input_ctrl with a rule-based reference model.
module tb_turn_input_ctrl;

    localparam int DIV  = 10;
    localparam int DEB  = 4;
    localparam int HIST = DEB + 2;

    logic       clock;
    logic       reset_n;
    logic       turn_btn;
    logic       hazard_sw;
    logic [1:0] mode;
    logic       step;
    logic       seq_clear;

    int n_vec;
    int n_mis;

    turn_input_ctrl #(
        .CLK_HZ         (100),
        .STEP_HZ        (10),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .turn_btn (turn_btn),
        .hazard_sw(hazard_sw),
        .mode     (mode),
        .step     (step),
        .seq_clear(seq_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a debounced value flips when the last DEB synchronised
    // samples (pin samples 2..DEB+1 edges ago) all disagree with it. Steps
    // fall on every DIV-th edge counted from reset or the last mode change.
    bit         hb[$];
    bit         hs[$];
    bit         m_bdb, m_bdb_p, m_sdb, m_sdb_p;
    int         m_turn, m_since;
    logic [1:0] m_mode;
    logic       m_step, m_clr;

    task automatic model_reset();
        hb.delete();
        hs.delete();
        for (int i = 0; i < HIST; i++) begin
            hb.push_back(1'b1);
            hs.push_back(1'b0);
        end
        m_bdb = 1; m_bdb_p = 1; m_sdb = 0; m_sdb_p = 0;
        m_turn = 0; m_since = 0;
        m_mode = 2'd0; m_step = 0; m_clr = 0;
    endtask

    task automatic model_edge();
        bit press, fb, fs;
        logic [1:0] nm;
        hb.push_back(turn_btn);
        hs.push_back(hazard_sw);
        if (hb.size() > HIST) void'(hb.pop_front());
        if (hs.size() > HIST) void'(hs.pop_front());
        press = m_bdb_p && !m_bdb && !m_sdb && !m_sdb_p;
        if (press) m_turn = (m_turn + 1) % 3;
        nm = m_sdb ? 2'd3 : 2'(m_turn);
        if (nm != m_mode) begin
            m_clr = 1; m_since = 0; m_step = 0;
        end else begin
            m_clr = 0; m_since++; m_step = ((m_since % DIV) == 0);
        end
        m_mode  = nm;
        m_bdb_p = m_bdb;
        m_sdb_p = m_sdb;
        fb = 1; fs = 1;
        for (int j = 2; j <= DEB + 1; j++) begin
            if (hb[HIST-1-j] == m_bdb) fb = 0;
            if (hs[HIST-1-j] == m_sdb) fs = 0;
        end
        if (fb) m_bdb = !m_bdb;
        if (fs) m_sdb = !m_sdb;
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_edge();
    end

    // Advance n cycles sampling at negedge; collects observations only.
    task automatic run_watch(input int n, output int lat, output int nclr,
                             output int nstep, output int fstep, output int ndiff);
        logic [1:0] m0;
        m0 = mode; lat = 0; nclr = 0; nstep = 0; fstep = 0; ndiff = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            if ({mode, step, seq_clear} !== {m_mode, m_step, m_clr}) ndiff++;
            if (seq_clear) nclr++;
            if (step) begin
                nstep++;
                if (fstep == 0) fstep = i;
            end
            if (lat == 0 && mode !== m0) lat = i;
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (3) @(negedge clock);
        n_vec++;
        if ({mode, step, seq_clear} !== 4'b0000) begin
            n_mis++;
            $display("FAIL reset_outputs got=%b/%b/%b want=0/0/0", mode, step, seq_clear);
        end
        reset_n = 1;
    endtask

    task automatic test_idle();
        int lat, nclr, nstep, fstep, ndiff;
        run_watch(50, lat, nclr, nstep, fstep, ndiff);
        n_vec++;
        if (ndiff !== 0) begin n_mis++; $display("FAIL idle_model got=%0d want=0 diff cycles", ndiff); end
        n_vec++;
        if (nstep !== 5 || fstep !== 10) begin
            n_mis++; $display("FAIL idle_steps got=%0d first=%0d want=5 first=10", nstep, fstep);
        end
        n_vec++;
        if (nclr !== 0 || mode !== 2'd0) begin
            n_mis++; $display("FAIL idle_mode got clr=%0d mode=%0d want clr=0 mode=0", nclr, mode);
        end
    endtask

    task automatic test_press_seq();
        logic [1:0] want [3] = '{2'd1, 2'd2, 2'd0};
        int lat, nclr, nstep, fstep, ndiff;
        for (int p = 0; p < 3; p++) begin
            turn_btn = 0;
            run_watch(20, lat, nclr, nstep, fstep, ndiff);
            n_vec++;
            if (lat !== 7 || nclr !== 1 || mode !== want[p] || ndiff !== 0) begin
                n_mis++;
                $display("FAIL press%0d got lat=%0d clr=%0d mode=%0d diff=%0d want lat=7 clr=1 mode=%0d diff=0",
                         p, lat, nclr, mode, ndiff, want[p]);
            end
            turn_btn = 1;
            run_watch($urandom_range(8, 14), lat, nclr, nstep, fstep, ndiff);
            n_vec++;
            if (nclr !== 0 || mode !== want[p] || ndiff !== 0) begin
                n_mis++;
                $display("FAIL release%0d got clr=%0d mode=%0d diff=%0d want clr=0 mode=%0d diff=0",
                         p, nclr, mode, ndiff, want[p]);
            end
        end
    endtask

    task automatic test_bounce();
        int lat, nclr, nstep, fstep, ndiff, tot_clr, tot_diff;
        tot_clr = 0; tot_diff = 0;
        for (int i = 0; i < 15; i++) begin
            turn_btn = (i % 2 == 0) ? 1'b0 : 1'b1;
            run_watch(2, lat, nclr, nstep, fstep, ndiff);
            tot_clr += nclr; tot_diff += ndiff;
        end
        turn_btn = 1;
        run_watch(10, lat, nclr, nstep, fstep, ndiff);
        tot_clr += nclr; tot_diff += ndiff;
        n_vec++;
        if (tot_clr !== 0 || mode !== 2'd0 || tot_diff !== 0) begin
            n_mis++;
            $display("FAIL bounce got clr=%0d mode=%0d diff=%0d want clr=0 mode=0 diff=0", tot_clr, mode, tot_diff);
        end
    endtask

    task automatic test_hazard();
        int lat, nclr, nstep, fstep, ndiff;
        turn_btn = 0;
        run_watch(10, lat, nclr, nstep, fstep, ndiff);
        turn_btn = 1;
        run_watch(8, lat, nclr, nstep, fstep, ndiff);
        n_vec++;
        if (mode !== 2'd1) begin n_mis++; $display("FAIL hz_setup got mode=%0d want=1", mode); end
        hazard_sw = 1;
        run_watch(12, lat, nclr, nstep, fstep, ndiff);
        n_vec++;
        if (lat !== 7 || nclr !== 1 || mode !== 2'd3 || ndiff !== 0) begin
            n_mis++;
            $display("FAIL hz_on got lat=%0d clr=%0d mode=%0d diff=%0d want lat=7 clr=1 mode=3 diff=0",
                     lat, nclr, mode, ndiff);
        end
        turn_btn = 0;
        run_watch(10, lat, nclr, nstep, fstep, ndiff);
        turn_btn = 1;
        run_watch(8, lat, nclr, nstep, fstep, ndiff);
        n_vec++;
        if (nclr !== 0 || mode !== 2'd3 || ndiff !== 0) begin
            n_mis++;
            $display("FAIL hz_press got clr=%0d mode=%0d diff=%0d want clr=0 mode=3 diff=0", nclr, mode, ndiff);
        end
        hazard_sw = 0;
        run_watch(12, lat, nclr, nstep, fstep, ndiff);
        n_vec++;
        if (lat !== 7 || nclr !== 1 || mode !== 2'd1 || ndiff !== 0) begin
            n_mis++;
            $display("FAIL hz_off got lat=%0d clr=%0d mode=%0d diff=%0d want lat=7 clr=1 mode=1 diff=0",
                     lat, nclr, mode, ndiff);
        end
    endtask

    task automatic test_step_collision();
        int w, chg_i, step_i, ndiff;
        logic [1:0] m0;
        w = 0;
        while (((m_since + 7) % DIV) != 0 && w < 20) begin
            @(negedge clock);
            w++;
        end
        n_vec++;
        if (w >= 20) begin n_mis++; $display("FAIL coll_align got wait=%0d want<20", w); end
        m0 = mode; chg_i = 0; step_i = 0; ndiff = 0;
        turn_btn = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clock);
            if ({mode, step, seq_clear} !== {m_mode, m_step, m_clr}) ndiff++;
            if (chg_i == 0 && mode !== m0) begin
                chg_i = i;
                n_vec++;
                if (step !== 1'b0 || seq_clear !== 1'b1 || mode !== 2'd2) begin
                    n_mis++;
                    $display("FAIL coll_edge got step=%b clr=%b mode=%0d want step=0 clr=1 mode=2",
                             step, seq_clear, mode);
                end
            end else if (chg_i != 0 && step_i == 0 && step) begin
                step_i = i;
            end
        end
        n_vec++;
        if (chg_i !== 7 || (step_i - chg_i) !== DIV || ndiff !== 0) begin
            n_mis++;
            $display("FAIL coll_timing got chg=%0d gap=%0d diff=%0d want chg=7 gap=%0d diff=0",
                     chg_i, step_i - chg_i, ndiff, DIV);
        end
        turn_btn = 1;
        repeat (8) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int w, lat, nclr, nstep, fstep, ndiff;
        w = 0;
        while ((m_since % DIV) != 5 && w < 20) begin
            @(negedge clock);
            w++;
        end
        n_vec++;
        if (mode !== 2'd2 || w >= 20) begin
            n_mis++; $display("FAIL rst_pre got mode=%0d wait=%0d want mode=2 wait<20", mode, w);
        end
        reset_n = 0;
        #1;
        n_vec++;
        if ({mode, step, seq_clear} !== 4'b0000) begin
            n_mis++;
            $display("FAIL rst_mid got=%b/%b/%b want=0/0/0", mode, step, seq_clear);
        end
        @(posedge clock);
        #2 reset_n = 1;
        @(negedge clock);
        run_watch(15, lat, nclr, nstep, fstep, ndiff);
        n_vec++;
        if (fstep !== DIV || nclr !== 0 || mode !== 2'd0 || ndiff !== 0) begin
            n_mis++;
            $display("FAIL rst_after got first_step=%0d clr=%0d mode=%0d diff=%0d want first_step=%0d clr=0 mode=0 diff=0",
                     fstep, nclr, mode, ndiff, DIV);
        end
    endtask

    task automatic test_random();
        int lat, nclr, nstep, fstep, ndiff;
        for (int s = 0; s < 80; s++) begin
            turn_btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) hazard_sw = ~hazard_sw;
            run_watch($urandom_range(1, 12), lat, nclr, nstep, fstep, ndiff);
            n_vec++;
            if (ndiff !== 0) begin
                n_mis++;
                $display("FAIL random seg=%0d got diff=%0d want=0 (mode=%0d exp=%0d)", s, ndiff, mode, m_mode);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_mis = 0;
        reset_n = 0;
        turn_btn = 1;
        hazard_sw = 0;
        test_reset();
        test_idle();
        test_press_seq();
        test_bounce();
        test_hazard();
        test_step_collision();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
